unary_stream_sched: RTL and testbench

- Round-robin scheduler that shares one `unary_gen` instance among NREQ requesters.
- Arbitrates among pending requests, captures the winner's 8-bit scalar and drives it into the generator.
- Holds the generator parked in reset between jobs and releases it for exactly one full 2^WIDTH-cycle stream.
- Re-labels the generator's bitstream with valid/last/id qualifiers for the downstream HDC encoder, and reports per-requester acknowledge and completion.

---
 rtl/unary_stream_sched.sv | 176 +++++++++++++++++
 tb/tb_unary_stream_sched.sv | 574 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unary_stream_sched.sv
// Round-robin front end for a single shared unary_gen instance.
// Grants one requester at a time, loads its scalar into the generator,
// releases the generator for one full 2^WIDTH-cycle stream, and tags
// every stream bit with valid/last/id for the downstream encoder.
module unary_stream_sched #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 10,
   parameter int IDW   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] req_scalar,
   output logic [NREQ-1:0]   ack,
   output logic [NREQ-1:0]   done,
   input  logic              abort,
   output logic              aborted,
   output logic              busy,
   output logic [IDW-1:0]    gnt_id,
   output logic [7:0]        gen_scalar,
   output logic              gen_rst,
   input  logic [WIDTH-1:0]  gen_count,
   input  logic              gen_bit,
   output logic              stream_bit,
   output logic              stream_valid,
   output logic              stream_last,
   output logic [IDW-1:0]    stream_id
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Scan index carries one extra bit so ptr + offset never overflows.
   localparam int             SW        = IDW + 1;
   localparam logic [SW-1:0]  NREQ_W    = SW'(NREQ);
   localparam logic [IDW-1:0] LAST_IDX  = IDW'(NREQ - 1);
   localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

   state_t           state_reg,        state_next;
   logic [IDW-1:0]   ptr_reg,          ptr_next;
   logic [IDW-1:0]   gnt_id_reg,       gnt_id_next;
   logic [7:0]       gen_scalar_reg,   gen_scalar_next;
   logic [NREQ-1:0]  ack_reg,          ack_next;
   logic [NREQ-1:0]  done_reg,         done_next;
   logic             aborted_reg,      aborted_next;
   logic             busy_reg,         busy_next;
   logic             gen_rst_reg,      gen_rst_next;
   logic             stream_valid_reg, stream_valid_next;
   logic             stream_last_reg,  stream_last_next;
   logic [IDW-1:0]   stream_id_reg,    stream_id_next;

   logic [7:0]       scalar_arr [NREQ];
   logic [IDW-1:0]   win_id;
   logic             win_found;
   logic [SW-1:0]    scan_idx;

   // Unpack the flat scalar bus into one byte per requester.
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign scalar_arr[gi] = req_scalar[8*gi +: 8];
      end
   endgenerate

   // Rotating priority: first asserted request at or above the pointer, wrapping.
   always_comb begin
      win_id    = ptr_reg;
      win_found = 1'b0;
      scan_idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = {1'b0, ptr_reg} + SW'(k);
         if (scan_idx >= NREQ_W) begin
            scan_idx = scan_idx - NREQ_W;
         end
         if (!win_found && req[scan_idx[IDW-1:0]]) begin
            win_found = 1'b1;
            win_id    = scan_idx[IDW-1:0];
         end
      end
   end

   // Next-state and next-output logic; pulses default low, held values default to hold.
   always_comb begin
      state_next        = state_reg;
      ptr_next          = ptr_reg;
      gnt_id_next       = gnt_id_reg;
      gen_scalar_next   = gen_scalar_reg;
      ack_next          = '0;
      done_next         = '0;
      aborted_next      = 1'b0;
      stream_valid_next = 1'b0;
      stream_last_next  = 1'b0;
      stream_id_next    = stream_id_reg;

      case (state_reg)
         IDLE: begin
            // abort is meaningless here and must not hold off a grant
            if (win_found) begin
               state_next        = RUN;
               gnt_id_next       = win_id;
               gen_scalar_next   = scalar_arr[win_id];
               ack_next[win_id]  = 1'b1;
               ptr_next          = (win_id == LAST_IDX) ? '0 : win_id + 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               // abort beats end-of-stream: the in-flight bit is dropped
               state_next   = IDLE;
               aborted_next = 1'b1;
            end else begin
               stream_valid_next = 1'b1;
               stream_id_next    = gnt_id_reg;
               stream_last_next  = (gen_count == COUNT_MAX);
               if (gen_count == COUNT_MAX) begin
                  // generator wraps to zero on this same edge by itself
                  state_next              = IDLE;
                  done_next[gnt_id_reg]   = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next    = (state_next == RUN);
      gen_rst_next = (state_next == IDLE);
   end

   // State and registered outputs, cleared by the active-low synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg        <= IDLE;
         ptr_reg          <= '0;
         gnt_id_reg       <= '0;
         gen_scalar_reg   <= '0;
         ack_reg          <= '0;
         done_reg         <= '0;
         aborted_reg      <= 1'b0;
         busy_reg         <= 1'b0;
         gen_rst_reg      <= 1'b1;
         stream_valid_reg <= 1'b0;
         stream_last_reg  <= 1'b0;
         stream_id_reg    <= '0;
      end else begin
         state_reg        <= state_next;
         ptr_reg          <= ptr_next;
         gnt_id_reg       <= gnt_id_next;
         gen_scalar_reg   <= gen_scalar_next;
         ack_reg          <= ack_next;
         done_reg         <= done_next;
         aborted_reg      <= aborted_next;
         busy_reg         <= busy_next;
         gen_rst_reg      <= gen_rst_next;
         stream_valid_reg <= stream_valid_next;
         stream_last_reg  <= stream_last_next;
         stream_id_reg    <= stream_id_next;
      end
   end

   assign ack          = ack_reg;
   assign done         = done_reg;
   assign aborted      = aborted_reg;
   assign busy         = busy_reg;
   assign gnt_id       = gnt_id_reg;
   assign gen_scalar   = gen_scalar_reg;
   assign gen_rst      = gen_rst_reg;
   assign stream_bit   = gen_bit;
   assign stream_valid = stream_valid_reg;
   assign stream_last  = stream_last_reg;
   assign stream_id    = stream_id_reg;

endmodule

// File: tb/tb_unary_stream_sched.sv
// Bench for unary_stream_sched: includes a stand-in unary_gen, a stream
// recorder, and a round-robin reference model; each scenario task checks
// the recorded jobs against values derived from the scheduling rules.
module tb_unary_stream_sched;
   localparam int NREQ  = 4;
   localparam int WIDTH = 10;
   localparam int IDW   = 2;
   localparam int LEN   = 1 << WIDTH;

   logic              clk        = 1'b0;
   logic              reset      = 1'b0;
   logic [NREQ-1:0]   req        = '0;
   logic [8*NREQ-1:0] req_scalar = '0;
   logic              abort      = 1'b0;
   logic [NREQ-1:0]   ack, done;
   logic              aborted, busy, gen_rst, stream_bit, stream_valid, stream_last;
   logic [IDW-1:0]    gnt_id, stream_id;
   logic [7:0]        gen_scalar;
   logic [WIDTH-1:0]  gen_count = '0;
   logic              gen_bit   = 1'b0;

   int n_vec = 0;
   int n_err = 0;
   int m_ptr = 0;

   typedef struct {
      int id; int len; int ones;
      bit ordered; bit id_ok; bit last_seen; bit done_ok;
      int start_cyc; int end_cyc;
   } job_t;

   job_t jobs [$];
   int   ack_q [$];
   int   ack_cyc_q [$];
   int   done_cnt  = 0;
   int   abort_cnt = 0;
   int   stray_cnt = 0;
   int   cyc       = 0;
   job_t cur;
   bit   in_job    = 1'b0;

   always #5 clk = ~clk;

   unary_stream_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk(clk), .reset(reset), .req(req), .req_scalar(req_scalar),
      .ack(ack), .done(done), .abort(abort), .aborted(aborted),
      .busy(busy), .gnt_id(gnt_id), .gen_scalar(gen_scalar), .gen_rst(gen_rst),
      .gen_count(gen_count), .gen_bit(gen_bit), .stream_bit(stream_bit),
      .stream_valid(stream_valid), .stream_last(stream_last), .stream_id(stream_id)
   );

   // Stand-in generator: counter held at zero by gen_rst, thermometer bit one cycle behind the count.
   always @(posedge clk) begin
      if (gen_rst) begin
         gen_count <= '0;
      end else begin
         gen_count <= gen_count + 1'b1;
         gen_bit   <= (int'(gen_count) < (int'(gen_scalar) << (WIDTH - 8)));
      end
   end

   // Recorder: groups contiguous valid cycles into jobs and logs pulses.
   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < NREQ; i++) begin
         if (ack[i]) begin
            ack_q.push_back(i);
            ack_cyc_q.push_back(cyc);
         end
      end
      if (done != '0) done_cnt++;
      if (aborted) abort_cnt++;
      if ((stream_last && !stream_valid) || (done != '0 && !stream_last)) stray_cnt++;
      if (stream_valid === 1'b1) begin
         if (!in_job) begin
            in_job = 1'b1;
            cur.id = int'(stream_id); cur.len = 0; cur.ones = 0;
            cur.ordered = 1'b1; cur.id_ok = 1'b1; cur.last_seen = 1'b0;
            cur.done_ok = 1'b0; cur.start_cyc = cyc; cur.end_cyc = cyc;
         end
         if (int'(stream_id) != cur.id) cur.id_ok = 1'b0;
         if (stream_bit && cur.ones != cur.len) cur.ordered = 1'b0;
         cur.len++;
         cur.ones += int'(stream_bit);
         if (stream_last) begin
            cur.last_seen = 1'b1;
            cur.done_ok   = (done == (NREQ'(1) << cur.id));
            cur.end_cyc   = cyc;
            jobs.push_back(cur);
            in_job = 1'b0;
         end
      end else if (in_job) begin
         cur.end_cyc = cyc - 1;
         jobs.push_back(cur);
         in_job = 1'b0;
      end
   end

   // Reference: first pending index at or above ptr, wrapping.
   function automatic int model_pick(input logic [NREQ-1:0] mask, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   // Reference: number of ones in a stream for a given scalar.
   function automatic int exp_ones(input int s);
      int t;
      t = s << (WIDTH - 8);
      return (t > LEN) ? LEN : t;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic clear_log();
      jobs.delete(); ack_q.delete(); ack_cyc_q.delete();
      done_cnt = 0; abort_cnt = 0; stray_cnt = 0;
   endtask

   task automatic wait_acks(input int n, input int budget, output bit ok);
      int t;
      t = 0;
      while (ack_q.size() < n && t < budget) begin
         step(1);
         t++;
      end
      ok = (ack_q.size() >= n);
   endtask

   task automatic wait_jobs(input int n, input int budget, output bit ok);
      int t;
      t = 0;
      while (jobs.size() < n && t < budget) begin
         step(1);
         t++;
      end
      ok = (jobs.size() >= n);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step(3);
      n_vec++;
      if ({ack, done, aborted, busy, gnt_id, gen_scalar, stream_valid, stream_last, stream_id} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got ack=%b done=%b abt=%b busy=%b gnt=%0d sc=%0d v=%b l=%b id=%0d, expected all 0",
                  ack, done, aborted, busy, gnt_id, gen_scalar, stream_valid, stream_last, stream_id);
      end
      n_vec++;
      if (gen_rst !== 1'b1) begin
         n_err++;
         $display("FAIL reset_gen_rst: got %b expected 1", gen_rst);
      end
      req = 4'b0100;
      req_scalar = {NREQ{8'($urandom_range(0, 255))}};
      step(2);
      n_vec++;
      if (ack !== '0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_holds_grant: got ack=%b busy=%b expected 0/0", ack, busy);
      end
      req = '0;
      reset = 1'b1;
      m_ptr = 0;
      step(3);
      clear_log();
      n_vec++;
      if (busy !== 1'b0 || gen_rst !== 1'b1 || ack !== '0) begin
         n_err++;
         $display("FAIL idle_no_req: got busy=%b gen_rst=%b ack=%b expected 0/1/0", busy, gen_rst, ack);
      end
   endtask

   task automatic test_single_job();
      bit ok;
      job_t j;
      clear_log();
      req_scalar[7:0] = 8'd100;
      req = 4'b0001;
      wait_acks(1, 20, ok);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL single_ack: got no ack expected ack[0]");
         req = '0;
         return;
      end
      n_vec++;
      if (ack_q[0] !== 0 || gnt_id !== 2'd0 || gen_scalar !== 8'd100 || busy !== 1'b1 || gen_rst !== 1'b0) begin
         n_err++;
         $display("FAIL single_grant: got ack_id=%0d gnt=%0d sc=%0d busy=%b gen_rst=%b expected 0/0/100/1/0",
                  ack_q[0], gnt_id, gen_scalar, busy, gen_rst);
      end
      req = '0;
      m_ptr = 1;
      wait_jobs(1, LEN + 20, ok);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL single_stream: got no completed stream expected 1");
         return;
      end
      j = jobs[0];
      n_vec++;
      if (j.len != LEN || j.ones != 400) begin
         n_err++;
         $display("FAIL single_counts: got len=%0d ones=%0d expected %0d/400", j.len, j.ones, LEN);
      end
      n_vec++;
      if (!j.ordered || !j.id_ok || j.id != 0) begin
         n_err++;
         $display("FAIL single_shape: got ordered=%b id_ok=%b id=%0d expected 1/1/0", j.ordered, j.id_ok, j.id);
      end
      n_vec++;
      if (!j.last_seen || !j.done_ok) begin
         n_err++;
         $display("FAIL single_last_done: got last=%b done_with_last=%b expected 1/1", j.last_seen, j.done_ok);
      end
      n_vec++;
      if (j.start_cyc - ack_cyc_q[0] != 1) begin
         n_err++;
         $display("FAIL single_latency: got %0d cycles ack->valid expected 1", j.start_cyc - ack_cyc_q[0]);
      end
      step(2);
      n_vec++;
      if (done_cnt != 1 || abort_cnt != 0 || stray_cnt != 0 || busy !== 1'b0 || gen_rst !== 1'b1 || ack_q.size() != 1) begin
         n_err++;
         $display("FAIL single_after: got done=%0d abt=%0d stray=%0d busy=%b gen_rst=%b acks=%0d expected 1/0/0/0/1/1",
                  done_cnt, abort_cnt, stray_cnt, busy, gen_rst, ack_q.size());
      end
   endtask

   task automatic test_round_robin();
      bit ok;
      int sc [NREQ] = '{0, 64, 128, 255};
      int exp_id;
      reset = 1'b0;
      step(1);
      reset = 1'b1;
      m_ptr = 0;
      clear_log();
      req_scalar = {8'd255, 8'd128, 8'd64, 8'd0};
      req = '1;
      wait_acks(5, 5 * (LEN + 2) + 20, ok);
      req = '0;
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL rr_acks: got %0d acks expected 5", ack_q.size());
         return;
      end
      wait_jobs(5, LEN + 20, ok);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL rr_jobs: got %0d jobs expected 5", jobs.size());
         return;
      end
      for (int n = 0; n < 5; n++) begin
         exp_id = model_pick('1, m_ptr);
         m_ptr  = (exp_id + 1) % NREQ;
         n_vec++;
         if (ack_q[n] != exp_id || jobs[n].id != exp_id) begin
            n_err++;
            $display("FAIL rr_order[%0d]: got ack=%0d stream_id=%0d expected %0d", n, ack_q[n], jobs[n].id, exp_id);
         end
         n_vec++;
         if (jobs[n].ones != exp_ones(sc[exp_id]) || jobs[n].len != LEN || !jobs[n].last_seen || !jobs[n].done_ok) begin
            n_err++;
            $display("FAIL rr_stream[%0d]: got ones=%0d len=%0d last=%b done=%b expected %0d/%0d/1/1",
                     n, jobs[n].ones, jobs[n].len, jobs[n].last_seen, jobs[n].done_ok, exp_ones(sc[exp_id]), LEN);
         end
         if (n > 0) begin
            n_vec++;
            if (jobs[n].start_cyc - jobs[n-1].end_cyc != 2) begin
               n_err++;
               $display("FAIL rr_gap[%0d]: got %0d idle cycles expected 1", n, jobs[n].start_cyc - jobs[n-1].end_cyc - 1);
            end
         end
      end
   endtask

   task automatic test_fairness();
      bit ok;
      int exp_seq [3] = '{2, 3, 1};
      logic [7:0] scal [NREQ];
      clear_log();
      for (int i = 0; i < NREQ; i++) begin
         scal[i] = 8'($urandom_range(0, 255));
         req_scalar[8*i +: 8] = scal[i];
      end
      req = 4'b0100;
      wait_acks(1, 20, ok);
      req = 4'b1010;
      wait_acks(2, LEN + 30, ok);
      req[3] = 1'b0;
      wait_acks(3, LEN + 30, ok);
      req = '0;
      m_ptr = 2;
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL fair_acks: got %0d acks expected 3", ack_q.size());
         return;
      end
      wait_jobs(3, LEN + 30, ok);
      for (int n = 0; n < 3; n++) begin
         n_vec++;
         if (ack_q[n] != exp_seq[n] || !ok || jobs[n].id != exp_seq[n] || jobs[n].ones != exp_ones(int'(scal[exp_seq[n]]))) begin
            n_err++;
            $display("FAIL fair_order[%0d]: got ack=%0d jobs=%0d expected id %0d ones %0d",
                     n, ack_q[n], jobs.size(), exp_seq[n], exp_ones(int'(scal[exp_seq[n]])));
         end
      end
   endtask

   task automatic test_random();
      bit ok;
      logic [NREQ-1:0] pend;
      logic [7:0] scal [NREQ];
      int exp_seq [NREQ];
      int nj, got;
      for (int r = 0; r < 3; r++) begin
         step(2);
         clear_log();
         pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int i = 0; i < NREQ; i++) begin
            scal[i] = 8'($urandom_range(0, 255));
            req_scalar[8*i +: 8] = scal[i];
         end
         req = pend;
         nj = $countones(pend);
         for (int n = 0; n < nj; n++) begin
            exp_seq[n] = model_pick(pend, m_ptr);
            wait_acks(n + 1, LEN + 30, ok);
            n_vec++;
            if (!ok) begin
               n_err++;
               $display("FAIL rand_ack[%0d.%0d]: got no ack expected id %0d", r, n, exp_seq[n]);
               req = '0;
               return;
            end
            got = ack_q[n];
            if (gen_scalar !== scal[exp_seq[n]] || got != exp_seq[n]) begin
               n_err++;
               $display("FAIL rand_grant[%0d.%0d]: got id=%0d sc=%0d expected id=%0d sc=%0d",
                        r, n, got, gen_scalar, exp_seq[n], scal[exp_seq[n]]);
            end
            m_ptr = (exp_seq[n] + 1) % NREQ;
            pend[got] = 1'b0;
            req[got]  = 1'b0;
         end
         wait_jobs(nj, LEN + 30, ok);
         for (int n = 0; n < nj; n++) begin
            n_vec++;
            if (!ok || jobs[n].id != exp_seq[n] || jobs[n].len != LEN || !jobs[n].ordered ||
                jobs[n].ones != exp_ones(int'(scal[exp_seq[n]])) || !jobs[n].done_ok) begin
               n_err++;
               $display("FAIL rand_stream[%0d.%0d]: got jobs=%0d id=%0d len=%0d ones=%0d expected id=%0d len=%0d ones=%0d",
                        r, n, jobs.size(), jobs[n].id, jobs[n].len, jobs[n].ones, exp_seq[n], LEN, exp_ones(int'(scal[exp_seq[n]])));
            end
         end
      end
   endtask

   task automatic test_abort();
      bit ok;
      int first, other;
      int s [2];
      step(2);
      clear_log();
      s[0] = $urandom_range(1, 255);
      s[1] = $urandom_range(1, 255);
      req_scalar[7:0]  = 8'(s[0]);
      req_scalar[15:8] = 8'(s[1]);
      first = model_pick(4'b0011, m_ptr);
      other = first ^ 1;
      req = 4'b0011;
      wait_acks(1, 20, ok);
      req[first] = 1'b0;
      m_ptr = (first + 1) % NREQ;
      n_vec++;
      if (!ok || ack_q[0] != first) begin
         n_err++;
         $display("FAIL abort_first_grant: got ok=%b id=%0d expected id %0d", ok, ack_q.size() > 0 ? ack_q[0] : -1, first);
         req = '0;
         return;
      end
      step(500);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      n_vec++;
      if (aborted !== 1'b1 || busy !== 1'b0 || stream_valid !== 1'b0 || stream_last !== 1'b0 || done !== '0) begin
         n_err++;
         $display("FAIL abort_pulse: got abt=%b busy=%b v=%b l=%b done=%b expected 1/0/0/0/0",
                  aborted, busy, stream_valid, stream_last, done);
      end
      step(1);
      n_vec++;
      if (ack !== (NREQ'(1) << other) || aborted !== 1'b0) begin
         n_err++;
         $display("FAIL abort_regrant: got ack=%b abt=%b expected ack[%0d] abt=0", ack, aborted, other);
      end
      req[other] = 1'b0;
      m_ptr = (other + 1) % NREQ;
      wait_jobs(2, LEN + 30, ok);
      n_vec++;
      if (!ok || jobs[0].len != 500 || jobs[0].last_seen || jobs[0].id != first ||
          jobs[0].ones != ((exp_ones(s[first]) < 500) ? exp_ones(s[first]) : 500)) begin
         n_err++;
         $display("FAIL abort_partial: got ok=%b len=%0d last=%b id=%0d ones=%0d expected len 500 last 0 id %0d",
                  ok, jobs[0].len, jobs[0].last_seen, jobs[0].id, jobs[0].ones, first);
         return;
      end
      n_vec++;
      if (jobs[1].len != LEN || jobs[1].ones != exp_ones(s[other]) || !jobs[1].ordered ||
          !jobs[1].done_ok || jobs[1].id != other || jobs[1].start_cyc - jobs[0].end_cyc != 3) begin
         n_err++;
         $display("FAIL abort_next: got len=%0d ones=%0d ord=%b done=%b id=%0d gap=%0d expected %0d/%0d/1/1/%0d/3",
                  jobs[1].len, jobs[1].ones, jobs[1].ordered, jobs[1].done_ok, jobs[1].id,
                  jobs[1].start_cyc - jobs[0].end_cyc, LEN, exp_ones(s[other]), other);
      end
      n_vec++;
      if (abort_cnt != 1 || done_cnt != 1 || stray_cnt != 0) begin
         n_err++;
         $display("FAIL abort_counts: got aborted=%0d done=%0d stray=%0d expected 1/1/0", abort_cnt, done_cnt, stray_cnt);
      end
   endtask

   task automatic test_abort_edges();
      bit ok;
      int t, s;
      step(2);
      clear_log();
      req_scalar[23:16] = 8'($urandom_range(0, 255));
      req = 4'b0100;
      wait_acks(1, 20, ok);
      req = '0;
      m_ptr = 3;
      t = 0;
      while (!(gen_count == {WIDTH{1'b1}} && busy) && t < LEN + 20) begin
         step(1);
         t++;
      end
      n_vec++;
      if (t >= LEN + 20) begin
         n_err++;
         $display("FAIL edge_reach_max: got no final count expected count %0d", LEN - 1);
         return;
      end
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      n_vec++;
      if (aborted !== 1'b1 || done !== '0 || stream_last !== 1'b0 || stream_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL edge_abort_at_max: got abt=%b done=%b l=%b v=%b busy=%b expected 1/0/0/0/0",
                  aborted, done, stream_last, stream_valid, busy);
      end
      step(2);
      n_vec++;
      if (jobs.size() != 1 || jobs[0].last_seen || jobs[0].len != LEN - 1 || done_cnt != 0) begin
         n_err++;
         $display("FAIL edge_max_record: got jobs=%0d len=%0d done=%0d expected 1/%0d/0",
                  jobs.size(), jobs.size() > 0 ? jobs[0].len : -1, done_cnt, LEN - 1);
      end
      clear_log();
      s = $urandom_range(0, 255);
      req_scalar[7:0] = 8'(s);
      abort = 1'b1;
      req = 4'b0001;
      wait_acks(1, 10, ok);
      abort = 1'b0;
      req = '0;
      n_vec++;
      if (!ok || ack_q[0] != model_pick(4'b0001, m_ptr) || abort_cnt != 0) begin
         n_err++;
         $display("FAIL edge_idle_abort_grant: got ok=%b aborted=%0d expected grant 0 aborted 0", ok, abort_cnt);
         return;
      end
      m_ptr = 1;
      wait_jobs(1, LEN + 20, ok);
      n_vec++;
      if (!ok || jobs[0].len != LEN || jobs[0].ones != exp_ones(s) || !jobs[0].done_ok || abort_cnt != 0) begin
         n_err++;
         $display("FAIL edge_idle_abort_stream: got ok=%b len=%0d ones=%0d aborted=%0d expected %0d/%0d/0",
                  ok, jobs[0].len, jobs[0].ones, abort_cnt, LEN, exp_ones(s));
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int e1, e3;
      logic [7:0] scal [NREQ];
      step(2);
      clear_log();
      for (int i = 0; i < NREQ; i++) begin
         scal[i] = 8'($urandom_range(0, 255));
         req_scalar[8*i +: 8] = scal[i];
      end
      req = 4'b0100;
      wait_acks(1, 20, ok);
      req = 4'b1010;
      step(300);
      reset = 1'b0;
      step(1);
      reset = 1'b1;
      n_vec++;
      if ({ack, done, aborted, busy, gnt_id, gen_scalar, stream_valid, stream_last, stream_id} !== '0 || gen_rst !== 1'b1) begin
         n_err++;
         $display("FAIL midreset_outputs: got ack=%b done=%b abt=%b busy=%b gnt=%0d sc=%0d v=%b l=%b gen_rst=%b expected zeros, gen_rst 1",
                  ack, done, aborted, busy, gnt_id, gen_scalar, stream_valid, stream_last, gen_rst);
      end
      m_ptr = 0;
      e1 = model_pick(4'b1010, m_ptr);
      wait_acks(2, 10, ok);
      n_vec++;
      if (!ok || ack_q[1] != e1) begin
         n_err++;
         $display("FAIL midreset_regrant: got ok=%b id=%0d expected %0d", ok, ack_q.size() > 1 ? ack_q[1] : -1, e1);
         req = '0;
         return;
      end
      req[e1] = 1'b0;
      m_ptr = (e1 + 1) % NREQ;
      e3 = model_pick(req, m_ptr);
      wait_acks(3, LEN + 30, ok);
      req = '0;
      m_ptr = (e3 + 1) % NREQ;
      wait_jobs(3, LEN + 30, ok);
      n_vec++;
      if (!ok || jobs[0].len != 300 || jobs[0].last_seen || done_cnt != 2 || abort_cnt != 0) begin
         n_err++;
         $display("FAIL midreset_discard: got ok=%b len=%0d last=%b done=%0d aborted=%0d expected 300/0/2/0",
                  ok, jobs[0].len, jobs[0].last_seen, done_cnt, abort_cnt);
         return;
      end
      n_vec++;
      if (jobs[1].id != e1 || jobs[1].ones != exp_ones(int'(scal[e1])) || jobs[2].id != e3 ||
          jobs[2].ones != exp_ones(int'(scal[e3])) || jobs[2].len != LEN) begin
         n_err++;
         $display("FAIL midreset_jobs: got ids %0d,%0d ones %0d,%0d expected ids %0d,%0d ones %0d,%0d",
                  jobs[1].id, jobs[2].id, jobs[1].ones, jobs[2].ones, e1, e3,
                  exp_ones(int'(scal[e1])), exp_ones(int'(scal[e3])));
      end
   endtask

   initial begin
      test_reset();
      test_single_job();
      test_round_robin();
      test_fairness();
      test_random();
      test_abort();
      test_abort_edges();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion by 2000000 time units expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
